mic_frame_ctrl: RTL and testbench

- Frame-buffer controller between the I2S microphone receiver and the HPS.
- Collects 4-channel 16-bit samples (mic set 1 L/R, mic set 2 L/R) into a ping-pong buffer of FRAME_LEN samples per bank.
- Hands each completed bank to the HPS with an interrupt, and reclaims it on software acknowledge.
- Exposes control/status registers and the ready bank over an Avalon-MM slave with read latency 1.

---
 rtl/audio_pkg.sv | 31 +++
 rtl/mic_frame_ctrl_if.sv | 24 ++
 rtl/frame_buf_ram.sv | 24 ++
 rtl/mic_frame_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mic_frame_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and types for the microphone frame controller
package audio_pkg;

   localparam logic [2:0] REG_CTRL      = 3'd0;
   localparam logic [2:0] REG_STATUS    = 3'd1;
   localparam logic [2:0] REG_FRAME_LEN = 3'd2;
   localparam logic [2:0] REG_ACK       = 3'd3;
   localparam logic [2:0] REG_OVF_CNT   = 3'd4;
   localparam logic [2:0] REG_FRAME_CNT = 3'd5;

   localparam int CTRL_ENABLE_BIT     = 0;
   localparam int CTRL_IRQ_EN_BIT     = 1;
   localparam int STAT_READY_BIT      = 0;
   localparam int STAT_READY_BANK_BIT = 1;
   localparam int STAT_OVERFLOW_BIT   = 2;
   localparam int STAT_FILL_BANK_BIT  = 3;

   typedef enum logic {
      IDLE,
      FILL
   } fill_state_e;

   // Lane order of sample_data, least significant lane first.
   typedef enum logic [1:0] {
      L1,
      R1,
      L2,
      R2
   } ch_e;

endpackage

// File: rtl/mic_frame_ctrl_if.sv
// rtl/mic_frame_ctrl_if.sv - sample stream and Avalon-MM slave bundle
interface mic_frame_ctrl_if #(
   parameter int ADDR_W = 11
);
   logic              sample_valid;
   logic [63:0]       sample_data;
   logic              chipselect;
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [15:0]       writedata;
   logic [15:0]       readdata;
   logic              irq;

   modport master (
      output sample_valid, sample_data, chipselect, read, write, address, writedata,
      input  readdata, irq
   );

   modport slave (
      input  sample_valid, sample_data, chipselect, read, write, address, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/frame_buf_ram.sv
// rtl/frame_buf_ram.sv - ping-pong sample store, one write port and one registered read port
module frame_buf_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [63:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [63:0]   rd_data
);
   logic [63:0] mem [2*DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end
endmodule

// File: rtl/mic_frame_ctrl.sv
// rtl/mic_frame_ctrl.sv - collects 4-channel samples into ping-pong frames and hands them to the HPS
module mic_frame_ctrl
   import audio_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH) + 3
) (
   input  logic            clk,
   input  logic            reset,
   mic_frame_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int LEN_W = IDX_W + 1;

   fill_state_e      state;
   logic             enable;
   logic             irq_en;
   logic [LEN_W-1:0] frame_len;
   logic [LEN_W-1:0] cur_len;
   logic [IDX_W-1:0] wr_idx;
   logic             fill_bank;
   logic             ready_bank;
   logic             ready;
   logic             overflow;
   logic             irq;
   logic [15:0]      ovf_cnt;
   logic [15:0]      frame_cnt;

   logic              buf_sel;
   logic [ADDR_W-2:0] addr_lo;
   logic              reg_hit;
   logic              wr_ctrl;
   logic              wr_len;
   logic              wr_ack;
   logic              rd_strobe;
   logic              irq_en_nxt;
   logic              take;
   logic              last;

   assign buf_sel   = bus.address[ADDR_W-1];
   assign addr_lo   = bus.address[ADDR_W-2:0];
   assign reg_hit   = !buf_sel && (addr_lo[ADDR_W-2:3] == '0);
   assign wr_ctrl   = bus.chipselect && bus.write && reg_hit && (addr_lo[2:0] == REG_CTRL);
   assign wr_len    = bus.chipselect && bus.write && reg_hit && (addr_lo[2:0] == REG_FRAME_LEN);
   assign wr_ack    = bus.chipselect && bus.write && reg_hit && (addr_lo[2:0] == REG_ACK);
   assign rd_strobe = bus.chipselect && bus.read;

   assign irq_en_nxt = wr_ctrl ? bus.writedata[CTRL_IRQ_EN_BIT] : irq_en;
   assign take       = (state == FILL) && enable && bus.sample_valid;
   assign last       = take && ({1'b0, wr_idx} == cur_len - 1'b1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         enable     <= 1'b0;
         irq_en     <= 1'b0;
         frame_len  <= LEN_W'(DEPTH);
         cur_len    <= LEN_W'(DEPTH);
         wr_idx     <= '0;
         fill_bank  <= 1'b0;
         ready_bank <= 1'b0;
         ready      <= 1'b0;
         overflow   <= 1'b0;
         irq        <= 1'b0;
         ovf_cnt    <= '0;
         frame_cnt  <= '0;
      end else begin
         if (wr_ctrl) begin
            enable <= bus.writedata[CTRL_ENABLE_BIT];
            irq_en <= bus.writedata[CTRL_IRQ_EN_BIT];
         end
         if (wr_len) begin
            frame_len <= (bus.writedata == 16'd0 || bus.writedata > 16'(DEPTH))
                         ? LEN_W'(DEPTH) : bus.writedata[LEN_W-1:0];
         end
         // The acknowledge is applied before any completion in the same cycle.
         if (wr_ack) begin
            ready <= 1'b0;
            irq   <= 1'b0;
            if (bus.writedata[0]) begin
               overflow <= 1'b0;
            end
         end

         case (state)
            IDLE: begin
               if (enable) begin
                  state   <= FILL;
                  cur_len <= frame_len;
                  wr_idx  <= '0;
               end
            end
            FILL: begin
               if (!enable) begin
                  state  <= IDLE;
                  wr_idx <= '0;
               end else if (take) begin
                  if (!last) begin
                     wr_idx <= wr_idx + 1'b1;
                  end else if (!ready || wr_ack) begin
                     ready_bank <= fill_bank;
                     fill_bank  <= ~fill_bank;
                     ready      <= 1'b1;
                     irq        <= irq_en_nxt;
                     frame_cnt  <= frame_cnt + 16'd1;
                     wr_idx     <= '0;
                     cur_len    <= frame_len;
                  end else begin
                     // The HPS still owns the other bank: drop this frame.
                     wr_idx   <= '0;
                     overflow <= 1'b1;
                     if (ovf_cnt != 16'hFFFF) begin
                        ovf_cnt <= ovf_cnt + 16'd1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (!irq_en_nxt) begin
            irq <= 1'b0;
         end
      end
   end

   logic [63:0] rd_word;
   logic [15:0] reg_rdata;
   logic [15:0] reg_q;
   logic        buf_q;
   ch_e         ch_q;
   logic [15:0] lane;

   frame_buf_ram #(
      .DEPTH(DEPTH)
   ) u_ram (
      .clk    (clk),
      .wr_en  (take),
      .wr_addr({fill_bank, wr_idx}),
      .wr_data(bus.sample_data),
      .rd_en  (rd_strobe && buf_sel),
      .rd_addr({ready_bank, addr_lo[ADDR_W-2:2]}),
      .rd_data(rd_word)
   );

   always_comb begin
      reg_rdata = '0;
      if (reg_hit) begin
         case (addr_lo[2:0])
            REG_CTRL:      reg_rdata = {14'd0, irq_en, enable};
            REG_STATUS:    reg_rdata = {12'd0, fill_bank, overflow, ready_bank, ready};
            REG_FRAME_LEN: reg_rdata = 16'(frame_len);
            REG_OVF_CNT:   reg_rdata = ovf_cnt;
            REG_FRAME_CNT: reg_rdata = frame_cnt;
            default:       reg_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reg_q <= '0;
         buf_q <= 1'b0;
         ch_q  <= L1;
      end else if (rd_strobe) begin
         reg_q <= reg_rdata;
         buf_q <= buf_sel;
         ch_q  <= ch_e'(addr_lo[1:0]);
      end
   end

   // The RAM output is already registered, so the lane mux sits after it.
   always_comb begin
      case (ch_q)
         L1:      lane = rd_word[15:0];
         R1:      lane = rd_word[31:16];
         L2:      lane = rd_word[47:32];
         R2:      lane = rd_word[63:48];
         default: lane = '0;
      endcase
   end

   assign bus.readdata = buf_q ? lane : reg_q;
   assign bus.irq      = irq;

endmodule

// File: tb/tb_mic_frame_ctrl.sv
// tb/tb_mic_frame_ctrl.sv - randomized self-checking bench for mic_frame_ctrl
module tb_mic_frame_ctrl;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   mic_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   mic_frame_ctrl #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus.slave)
   );

   int checks = 0;
   int passed = 0;

   // Reference model: frame bookkeeping kept as plain counters and a sample array.
   int          m_frame_len, m_cur_len, m_wr, m_rlen, m_ovf_cnt, m_frame_cnt;
   bit          m_en, m_irq_en, m_filling, m_ready, m_rb, m_fb, m_ovf, m_irq;
   logic [63:0] m_mem [2][DEPTH];

   task automatic model_reset();
      m_frame_len = DEPTH; m_cur_len = DEPTH; m_wr = 0; m_rlen = 0;
      m_ovf_cnt = 0; m_frame_cnt = 0;
      m_en = 0; m_irq_en = 0; m_filling = 0; m_ready = 0;
      m_rb = 0; m_fb = 0; m_ovf = 0; m_irq = 0;
   endtask

   function automatic logic [15:0] m_status();
      return {12'd0, m_fb, m_ovf, m_rb, m_ready};
   endfunction

   task automatic model_ack(input logic [15:0] v);
      m_ready = 0;
      m_irq   = 0;
      if (v[0]) m_ovf = 0;
   endtask

   task automatic model_push(input logic [63:0] s, input bit ack, input logic [15:0] av);
      if (ack) model_ack(av);
      if (!m_filling) return;
      m_mem[m_fb][m_wr] = s;
      if (m_wr + 1 < m_cur_len) begin
         m_wr++;
      end else if (!m_ready) begin
         m_rlen = m_cur_len;
         m_rb = m_fb; m_fb = !m_fb; m_ready = 1; m_irq = m_irq_en;
         m_frame_cnt = (m_frame_cnt + 1) % 65536;
         m_wr = 0; m_cur_len = m_frame_len;
      end else begin
         m_wr = 0; m_ovf = 1;
         if (m_ovf_cnt < 65535) m_ovf_cnt++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic avl_wr(input int a, input logic [15:0] d);
      bus.chipselect = 1'b1; bus.write = 1'b1;
      bus.address = ADDR_W'(a); bus.writedata = d;
      tick();
      bus.chipselect = 1'b0; bus.write = 1'b0;
   endtask

   task automatic avl_rd(input int a, output logic [15:0] d);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = ADDR_W'(a);
      tick();
      bus.chipselect = 1'b0; bus.read = 1'b0;
      d = bus.readdata;
   endtask

   function automatic int buf_addr(input int idx, input int ch);
      return 1024 + idx * 4 + ch;
   endfunction

   task automatic wr_ctrl(input logic [15:0] v);
      avl_wr(0, v);
      if (v[0] && !m_en) begin m_filling = 1; m_cur_len = m_frame_len; m_wr = 0; end
      if (!v[0]) begin m_filling = 0; m_wr = 0; end
      m_en = v[0]; m_irq_en = v[1];
      if (!m_irq_en) m_irq = 0;
      tick();
   endtask

   task automatic wr_len(input logic [15:0] v);
      avl_wr(2, v);
      m_frame_len = (v == 0 || v > DEPTH) ? DEPTH : int'(v);
   endtask

   task automatic wr_ack(input logic [15:0] v);
      avl_wr(3, v);
      model_ack(v);
   endtask

   task automatic push(input logic [63:0] s);
      bus.sample_valid = 1'b1; bus.sample_data = s;
      tick();
      bus.sample_valid = 1'b0;
      model_push(s, 0, 16'd0);
   endtask

   task automatic push_ack(input logic [63:0] s, input logic [15:0] av);
      bus.sample_valid = 1'b1; bus.sample_data = s;
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = ADDR_W'(3); bus.writedata = av;
      tick();
      bus.sample_valid = 1'b0; bus.chipselect = 1'b0; bus.write = 1'b0;
      model_push(s, 1, av);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic test_reset();
      logic [15:0] d;
      checks++; if (bus.readdata !== 16'h0) $display("FAIL reset_readdata got %h exp 0000", bus.readdata); else passed++;
      checks++; if (bus.irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", bus.irq); else passed++;
      avl_rd(1, d);
      checks++; if (d !== 16'h0000) $display("FAIL reset_status got %h exp 0000", d); else passed++;
      avl_rd(2, d);
      checks++; if (d !== 16'h0100) $display("FAIL reset_frame_len got %h exp 0100", d); else passed++;
      avl_rd(4, d);
      checks++; if (d !== 16'h0000) $display("FAIL reset_ovf_cnt got %h exp 0000", d); else passed++;
      avl_rd(5, d);
      checks++; if (d !== 16'h0000) $display("FAIL reset_frame_cnt got %h exp 0000", d); else passed++;
      avl_rd(7, d);
      checks++; if (d !== 16'h0000) $display("FAIL unmapped_read got %h exp 0000", d); else passed++;
   endtask

   task automatic test_frame();
      logic [15:0] d;
      logic [63:0] s;
      wr_len(4);
      wr_ctrl(3);
      for (int n = 0; n < 4; n++) begin
         s = rnd64();
         s[15:0] = 16'h1000 + 16'(n);
         push(s);
         checks++;
         if (bus.irq !== m_irq) $display("FAIL frame_irq n=%0d got %b exp %b", n, bus.irq, m_irq); else passed++;
      end
      avl_rd(1, d);
      checks++; if (d !== 16'h0009 || d !== m_status()) $display("FAIL frame_status got %h exp 0009", d); else passed++;
      avl_rd(buf_addr(2, 0), d);
      checks++; if (d !== 16'h1002) $display("FAIL frame_buf_idx2 got %h exp 1002", d); else passed++;
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 4; c++) begin
            avl_rd(buf_addr(i, c), d);
            checks++;
            if (d !== m_mem[m_rb][i][c*16 +: 16]) $display("FAIL frame_buf i=%0d ch=%0d got %h exp %h", i, c, d, m_mem[m_rb][i][c*16 +: 16]);
            else passed++;
         end
      end
      avl_rd(5, d);
      checks++; if (d !== 16'd1) $display("FAIL frame_cnt got %0d exp 1", d); else passed++;
   endtask

   task automatic test_overflow();
      logic [15:0] d;
      for (int n = 0; n < 4; n++) push(rnd64());
      avl_rd(1, d);
      checks++; if (d !== 16'h000D || d !== m_status()) $display("FAIL ovf_status got %h exp 000d", d); else passed++;
      avl_rd(4, d);
      checks++; if (d !== 16'd1) $display("FAIL ovf_cnt got %0d exp 1", d); else passed++;
      checks++; if (bus.irq !== 1'b1) $display("FAIL ovf_irq_held got %b exp 1", bus.irq); else passed++;
      wr_ack(16'h1);
      checks++; if (bus.irq !== 1'b0) $display("FAIL ack_irq got %b exp 0", bus.irq); else passed++;
      avl_rd(1, d);
      checks++; if (d !== 16'h0008) $display("FAIL ack_status got %h exp 0008", d); else passed++;
   endtask

   task automatic test_ack_collision();
      logic [15:0] d;
      for (int n = 0; n < 4; n++) push(rnd64());
      for (int n = 0; n < 3; n++) push(rnd64());
      push_ack(rnd64(), 16'h0);
      avl_rd(1, d);
      checks++; if (d !== 16'h0009 || d !== m_status()) $display("FAIL collide_status got %h exp 0009", d); else passed++;
      checks++; if (bus.irq !== 1'b1) $display("FAIL collide_irq got %b exp 1", bus.irq); else passed++;
      avl_rd(4, d);
      checks++; if (d !== 16'(m_ovf_cnt)) $display("FAIL collide_ovf_cnt got %0d exp %0d", d, m_ovf_cnt); else passed++;
      avl_rd(buf_addr(3, 3), d);
      checks++; if (d !== m_mem[m_rb][3][63:48]) $display("FAIL collide_buf got %h exp %h", d, m_mem[m_rb][3][63:48]); else passed++;
   endtask

   task automatic test_abort();
      logic [15:0] d;
      wr_ack(16'h1);
      push(64'hDEAD_DEAD_DEAD_DEAD);
      push(64'hDEAD_DEAD_DEAD_DEAD);
      wr_ctrl(2);
      push(64'hBEEF_BEEF_BEEF_BEEF);
      wr_ctrl(3);
      for (int n = 0; n < 4; n++) push(rnd64());
      avl_rd(1, d);
      checks++; if (d !== m_status() || d[0] !== 1'b1) $display("FAIL abort_status got %h exp %h", d, m_status()); else passed++;
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 4; c++) begin
            avl_rd(buf_addr(i, c), d);
            checks++;
            if (d !== m_mem[m_rb][i][c*16 +: 16]) $display("FAIL abort_buf i=%0d ch=%0d got %h exp %h", i, c, d, m_mem[m_rb][i][c*16 +: 16]);
            else passed++;
         end
      end
      wr_ctrl(1);
      checks++; if (bus.irq !== 1'b0) $display("FAIL irq_en_clear got %b exp 0", bus.irq); else passed++;
      avl_rd(1, d);
      checks++; if (d[0] !== 1'b1) $display("FAIL irq_en_clear_ready got %b exp 1", d[0]); else passed++;
      wr_ctrl(3);
   endtask

   task automatic test_frame_len();
      logic [15:0] d;
      wr_ack(16'h1);
      wr_len(0);
      avl_rd(2, d);
      checks++; if (d !== 16'h0100) $display("FAIL len_zero got %h exp 0100", d); else passed++;
      wr_len(300);
      avl_rd(2, d);
      checks++; if (d !== 16'h0100) $display("FAIL len_over got %h exp 0100", d); else passed++;
      push(rnd64()); push(rnd64());
      wr_len(8);
      push(rnd64()); push(rnd64());
      checks++; if (bus.irq !== 1'b1) $display("FAIL len_old_frame_irq got %b exp 1", bus.irq); else passed++;
      wr_ack(16'h0);
      for (int n = 0; n < 7; n++) push(rnd64());
      checks++; if (bus.irq !== 1'b0) $display("FAIL len_new_frame_early got %b exp 0", bus.irq); else passed++;
      push(rnd64());
      checks++; if (bus.irq !== 1'b1) $display("FAIL len_new_frame_irq got %b exp 1", bus.irq); else passed++;
      avl_rd(buf_addr(7, 2), d);
      checks++; if (d !== m_mem[m_rb][7][47:32]) $display("FAIL len_buf7 got %h exp %h", d, m_mem[m_rb][7][47:32]); else passed++;
   endtask

   task automatic test_random();
      logic [15:0] d;
      int r, idx, ch;
      wr_ack(16'h1);
      wr_len(16'($urandom_range(1, 5)));
      for (int it = 0; it < 150; it++) begin
         r = $urandom_range(0, 11);
         if (r <= 6) push(rnd64());
         else if (r == 7) wr_ack(16'($urandom_range(0, 1)));
         else if (r == 8) wr_ctrl(($urandom_range(0, 7) == 0) ? 16'h2 : 16'($urandom_range(1, 3) | 1));
         else if (r == 9) wr_len(16'($urandom_range(1, 5)));
         else if (r == 10 && m_ready) begin
            idx = $urandom_range(0, m_rlen - 1);
            ch  = $urandom_range(0, 3);
            avl_rd(buf_addr(idx, ch), d);
            checks++;
            if (d !== m_mem[m_rb][idx][ch*16 +: 16]) $display("FAIL rnd_buf it=%0d got %h exp %h", it, d, m_mem[m_rb][idx][ch*16 +: 16]);
            else passed++;
         end else if (m_ready && $urandom_range(0, 1) == 0) begin
            push_ack(rnd64(), 16'($urandom_range(0, 1)));
         end else begin
            avl_rd(1, d);
            checks++; if (d !== m_status()) $display("FAIL rnd_status it=%0d got %h exp %h", it, d, m_status()); else passed++;
         end
         checks++; if (bus.irq !== m_irq) $display("FAIL rnd_irq it=%0d got %b exp %b", it, bus.irq, m_irq); else passed++;
      end
      avl_rd(4, d);
      checks++; if (d !== 16'(m_ovf_cnt)) $display("FAIL rnd_ovf_cnt got %0d exp %0d", d, m_ovf_cnt); else passed++;
      avl_rd(5, d);
      checks++; if (d !== 16'(m_frame_cnt)) $display("FAIL rnd_frame_cnt got %0d exp %0d", d, m_frame_cnt); else passed++;
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] d;
      wr_ctrl(3);
      push(rnd64());
      rst_n = 1'b0;
      tick();
      checks++; if (bus.irq !== 1'b0) $display("FAIL midreset_irq got %b exp 0", bus.irq); else passed++;
      rst_n = 1'b1;
      model_reset();
      tick();
      avl_rd(1, d);
      checks++; if (d !== 16'h0000) $display("FAIL midreset_status got %h exp 0000", d); else passed++;
      avl_rd(5, d);
      checks++; if (d !== 16'h0000) $display("FAIL midreset_frame_cnt got %h exp 0000", d); else passed++;
   endtask

   initial begin
      bus.sample_valid = 1'b0; bus.sample_data = '0;
      bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.address = '0; bus.writedata = '0;
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_frame();
      test_overflow();
      test_ack_collision();
      test_abort();
      test_frame_len();
      test_random();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
